branch_resolve: RTL and testbench

Execute-stage branch resolution unit that sits directly downstream of the 2-bit-counter BHT. It carries each fetched instruction's prediction (taken bit from the BHT, predicted target, PC) through the decode and execute pipeline registers. In execute it compares the prediction with the actual branch outcome. It produces the BHT update interface (update strobe, taken, exec set index), the mispredict flush/redirect, and saturating performance counters.

---
 rtl/branch_resolve.sv | 126 ++++++++++++
 tb/tb_branch_resolve.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: carries BHT predictions through the D/E pipeline
// registers, checks them against the resolved outcome, drives BHT update and redirect.
module branch_resolve #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INDEX_WIDTH = 5,
    parameter int COUNT_W     = 32
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   i_fetch_valid,
    input  logic [ADDR_WIDTH-1:0]  i_fetch_pc,
    input  logic                   i_pred_taken,
    input  logic [ADDR_WIDTH-1:0]  i_pred_target,
    input  logic                   i_stall_exec,
    input  logic                   i_flush,
    input  logic                   i_exec_is_branch,
    input  logic                   i_exec_taken,
    input  logic [ADDR_WIDTH-1:0]  i_exec_target,
    output logic                   o_bht_update,
    output logic                   o_branch_taken,
    output logic [INDEX_WIDTH-1:0] o_set_index_exec,
    output logic                   o_mispredict,
    output logic [ADDR_WIDTH-1:0]  o_redirect_pc,
    output logic [COUNT_W-1:0]     o_branch_cnt,
    output logic [COUNT_W-1:0]     o_mispred_cnt
);

    logic                  d_valid_q, d_valid_d;
    logic [ADDR_WIDTH-1:0] d_pc_q, d_pc_d;
    logic                  d_pred_taken_q, d_pred_taken_d;
    logic [ADDR_WIDTH-1:0] d_pred_target_q, d_pred_target_d;

    logic                  e_valid_q, e_valid_d;
    logic [ADDR_WIDTH-1:0] e_pc_q, e_pc_d;
    logic                  e_pred_taken_q, e_pred_taken_d;
    logic [ADDR_WIDTH-1:0] e_pred_target_q, e_pred_target_d;

    logic [COUNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [COUNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;

    logic                  resolve;
    logic                  dir_wrong;
    logic                  target_wrong;
    logic                  mispredict;
    logic                  kill;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    assign resolve      = e_valid_q & i_exec_is_branch & ~i_stall_exec;
    assign dir_wrong    = i_exec_taken != e_pred_taken_q;
    assign target_wrong = i_exec_taken & e_pred_taken_q & (i_exec_target != e_pred_target_q);
    assign mispredict   = resolve & (dir_wrong | target_wrong);
    assign kill         = i_flush | mispredict;
    assign redirect_pc  = i_exec_taken ? i_exec_target : (e_pc_q + ADDR_WIDTH'(4));

    // Kill beats hold beats load; a kill drops only the valid bits.
    always_comb begin
        d_valid_d       = d_valid_q;
        d_pc_d          = d_pc_q;
        d_pred_taken_d  = d_pred_taken_q;
        d_pred_target_d = d_pred_target_q;
        e_valid_d       = e_valid_q;
        e_pc_d          = e_pc_q;
        e_pred_taken_d  = e_pred_taken_q;
        e_pred_target_d = e_pred_target_q;
        if (kill) begin
            d_valid_d = 1'b0;
            e_valid_d = 1'b0;
        end else if (!i_stall_exec) begin
            d_valid_d       = i_fetch_valid;
            d_pc_d          = i_fetch_pc;
            d_pred_taken_d  = i_pred_taken;
            d_pred_target_d = i_pred_target;
            e_valid_d       = d_valid_q;
            e_pc_d          = d_pc_q;
            e_pred_taken_d  = d_pred_taken_q;
            e_pred_target_d = d_pred_target_q;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && (branch_cnt_q != {COUNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + COUNT_W'(1);
        end
        if (mispredict && (mispred_cnt_q != {COUNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            d_valid_q       <= 1'b0;
            d_pc_q          <= '0;
            d_pred_taken_q  <= 1'b0;
            d_pred_target_q <= '0;
            e_valid_q       <= 1'b0;
            e_pc_q          <= '0;
            e_pred_taken_q  <= 1'b0;
            e_pred_target_q <= '0;
            branch_cnt_q    <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            d_valid_q       <= d_valid_d;
            d_pc_q          <= d_pc_d;
            d_pred_taken_q  <= d_pred_taken_d;
            d_pred_target_q <= d_pred_target_d;
            e_valid_q       <= e_valid_d;
            e_pc_q          <= e_pc_d;
            e_pred_taken_q  <= e_pred_taken_d;
            e_pred_target_q <= e_pred_target_d;
            branch_cnt_q    <= branch_cnt_d;
            mispred_cnt_q   <= mispred_cnt_d;
        end
    end

    // Pass-through outputs are gated by reset so everything reads 0 while reset is held.
    assign o_bht_update     = resolve;
    assign o_mispredict     = mispredict;
    assign o_branch_taken   = i_exec_taken & i_arst_n;
    assign o_set_index_exec = e_pc_q[INDEX_WIDTH+1:2] & {INDEX_WIDTH{i_arst_n}};
    assign o_redirect_pc    = redirect_pc & {ADDR_WIDTH{i_arst_n}};
    assign o_branch_cnt     = branch_cnt_q;
    assign o_mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: vector table for single-branch resolution plus
// sequences for kill, stall, flush, counter saturation and async reset.
module tb_branch_resolve;

    localparam int AW = 64;
    localparam int IW = 5;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          fetch_valid;
    logic [AW-1:0] fetch_pc;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          stall;
    logic          flush;
    logic          ex_br;
    logic          ex_taken;
    logic [AW-1:0] ex_target;
    logic          bht_update;
    logic          br_taken;
    logic [IW-1:0] set_index;
    logic          mispredict;
    logic [AW-1:0] redirect_pc;
    logic [CW-1:0] br_cnt;
    logic [CW-1:0] mp_cnt;

    branch_resolve #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .COUNT_W(CW)) dut (
        .i_clk(clk),
        .i_arst_n(rst_n),
        .i_fetch_valid(fetch_valid),
        .i_fetch_pc(fetch_pc),
        .i_pred_taken(pred_taken),
        .i_pred_target(pred_target),
        .i_stall_exec(stall),
        .i_flush(flush),
        .i_exec_is_branch(ex_br),
        .i_exec_taken(ex_taken),
        .i_exec_target(ex_target),
        .o_bht_update(bht_update),
        .o_branch_taken(br_taken),
        .o_set_index_exec(set_index),
        .o_mispredict(mispredict),
        .o_redirect_pc(redirect_pc),
        .o_branch_cnt(br_cnt),
        .o_mispred_cnt(mp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic          pt;
        logic [AW-1:0] ptgt;
        logic          isb;
        logic          tk;
        logic [AW-1:0] tgt;
        logic          exp_upd;
        logic          exp_mp;
        logic [AW-1:0] exp_redir;
        logic [IW-1:0] exp_idx;
    } vec_t;

    vec_t vecs[10];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_br = 0;
    int   exp_mp = 0;

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [AW-1:0] pc, input logic pt, input logic [AW-1:0] tgt);
        fetch_valid = v;
        fetch_pc    = pc;
        pred_taken  = pt;
        pred_target = tgt;
    endtask

    task automatic exec(input logic b, input logic t, input logic [AW-1:0] tgt);
        ex_br     = b;
        ex_taken  = t;
        ex_target = tgt;
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, "_brcnt"}, AW'(br_cnt), AW'(exp_br));
        chk({nm, "_mpcnt"}, AW'(mp_cnt), AW'(exp_mp));
    endtask

    initial begin
        //         pc                     pt    ptgt     isb   tk    tgt      upd   mp    redirect   idx
        vecs[0] = '{64'h100,              1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 64'h104,   5'd0};
        vecs[1] = '{64'h104,              1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 64'h108,   5'd1};
        vecs[2] = '{64'h108,              1'b1, 64'h500, 1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 64'h10C,   5'd2};
        vecs[3] = '{64'h200,              1'b1, 64'h240, 1'b1, 1'b1, 64'h240, 1'b1, 1'b0, 64'h240,   5'd0};
        vecs[4] = '{64'h20C,              1'b1, 64'h300, 1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h210,   5'd3};
        vecs[5] = '{64'h400,              1'b1, 64'h300, 1'b1, 1'b1, 64'h380, 1'b1, 1'b1, 64'h380,   5'd0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h40, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'h0,     5'd31};
        vecs[7] = '{64'h044,              1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 64'h48,    5'd17};
        vecs[8] = '{64'h07C,              1'b0, 64'h0,   1'b1, 1'b1, 64'h1000, 1'b1, 1'b1, 64'h1000, 5'd31};
        vecs[9] = '{64'h300,              1'b1, 64'h280, 1'b1, 1'b1, 64'h280, 1'b1, 1'b0, 64'h280,   5'd0};

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        fetch(1'b1, 64'h100, 1'b1, 64'h123);
        exec(1'b1, 1'b1, 64'hABC);
        #2;
        chk("rst_update", AW'(bht_update), 0);
        chk("rst_mispred", AW'(mispredict), 0);
        chk("rst_taken", AW'(br_taken), 0);
        chk("rst_index", AW'(set_index), 0);
        chk("rst_redirect", redirect_pc, 0);
        chk_cnt("rst");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        fetch(1'b0, 0, 1'b0, 0);
        exec(1'b0, 1'b0, 0);
        tick();

        for (int i = 0; i < 10; i++) begin
            exec(1'b0, 1'b0, 0);
            fetch(1'b1, vecs[i].pc, vecs[i].pt, vecs[i].ptgt);
            tick();
            fetch(1'b0, 0, 1'b0, 0);
            tick();
            exec(vecs[i].isb, vecs[i].tk, vecs[i].tgt);
            #2;
            chk($sformatf("v%0d_update", i), AW'(bht_update), AW'(vecs[i].exp_upd));
            chk($sformatf("v%0d_mispred", i), AW'(mispredict), AW'(vecs[i].exp_mp));
            chk($sformatf("v%0d_taken", i), AW'(br_taken), AW'(vecs[i].tk));
            chk($sformatf("v%0d_index", i), AW'(set_index), AW'(vecs[i].exp_idx));
            chk($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].exp_redir);
            if (vecs[i].exp_upd) exp_br = sat(exp_br);
            if (vecs[i].exp_mp) exp_mp = sat(exp_mp);
            tick();
            chk_cnt($sformatf("v%0d", i));
        end

        // Mispredict kills both stages; the redirected fetch resolves normally afterwards.
        exec(1'b0, 1'b0, 0);
        fetch(1'b1, 64'h20C, 1'b1, 64'h300);
        tick();
        fetch(1'b1, 64'h500, 1'b0, 0);
        tick();
        fetch(1'b1, 64'h600, 1'b0, 0);
        exec(1'b1, 1'b0, 0);
        #2;
        chk("kill_mispred", AW'(mispredict), 1);
        chk("kill_redirect", redirect_pc, 64'h210);
        exp_br = sat(exp_br);
        exp_mp = sat(exp_mp);
        tick();
        fetch(1'b1, 64'h210, 1'b0, 0);
        #2;
        chk("kill_e_empty", AW'(bht_update), 0);
        tick();
        fetch(1'b0, 0, 1'b0, 0);
        #2;
        chk("kill_d_empty", AW'(bht_update), 0);
        tick();
        #2;
        chk("redir_update", AW'(bht_update), 1);
        chk("redir_index", AW'(set_index), 5'd4);
        chk("redir_mispred", AW'(mispredict), 0);
        exp_br = sat(exp_br);
        tick();
        exec(1'b0, 1'b0, 0);
        chk_cnt("kill");

        // Stall for 3 cycles with a branch in E: one update only once the stall drops.
        fetch(1'b1, 64'h044, 1'b0, 0);
        tick();
        fetch(1'b0, 0, 1'b0, 0);
        tick();
        stall = 1'b1;
        exec(1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            fetch(1'b1, 64'h900, 1'b1, 64'h0);
            #2;
            chk($sformatf("stall%0d_update", i), AW'(bht_update), 0);
            chk($sformatf("stall%0d_mispred", i), AW'(mispredict), 0);
            tick();
        end
        chk_cnt("stall_hold");
        stall = 1'b0;
        fetch(1'b0, 0, 1'b0, 0);
        #2;
        chk("stall_drop_update", AW'(bht_update), 1);
        chk("stall_drop_index", AW'(set_index), 5'd17);
        exp_br = sat(exp_br);
        tick();
        #2;
        chk("stall_no_repeat", AW'(bht_update), 0);
        tick();
        exec(1'b0, 1'b0, 0);
        chk_cnt("stall");

        // Flush concurrent with a mispredict: reported and counted once, both stages dropped.
        fetch(1'b1, 64'h20C, 1'b1, 64'h300);
        tick();
        fetch(1'b1, 64'h500, 1'b0, 0);
        tick();
        fetch(1'b0, 0, 1'b0, 0);
        flush = 1'b1;
        exec(1'b1, 1'b0, 0);
        #2;
        chk("flmp_mispred", AW'(mispredict), 1);
        exp_br = sat(exp_br);
        exp_mp = sat(exp_mp);
        tick();
        flush = 1'b0;
        #2;
        chk("flmp_e_empty", AW'(bht_update), 0);
        tick();
        #2;
        chk("flmp_d_empty", AW'(bht_update), 0);
        tick();
        chk_cnt("flmp");

        // Flush alone kills an entry sitting in D; counters untouched.
        exec(1'b0, 1'b0, 0);
        fetch(1'b1, 64'h600, 1'b0, 0);
        tick();
        fetch(1'b0, 0, 1'b0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exec(1'b1, 1'b0, 0);
        #2;
        chk("flush_e_empty", AW'(bht_update), 0);
        tick();
        #2;
        chk("flush_d_empty", AW'(bht_update), 0);
        tick();
        chk_cnt("flush");

        // Drive 20 mispredicts into the 4-bit counters.
        for (int i = 0; i < 20; i++) begin
            exec(1'b0, 1'b0, 0);
            fetch(1'b1, 64'h20C, 1'b1, 64'h300);
            tick();
            fetch(1'b0, 0, 1'b0, 0);
            tick();
            exec(1'b1, 1'b0, 0);
            exp_br = sat(exp_br);
            exp_mp = sat(exp_mp);
            tick();
        end
        exec(1'b0, 1'b0, 0);
        chk("sat_brcnt", AW'(br_cnt), 64'hF);
        chk("sat_mpcnt", AW'(mp_cnt), 64'hF);

        // Async reset with a mispredicting branch in E, between clock edges.
        fetch(1'b1, 64'h2A0, 1'b1, 64'h2C0);
        tick();
        fetch(1'b0, 0, 1'b0, 0);
        tick();
        exec(1'b1, 1'b1, 64'h2C4);
        #2;
        chk("arst_pre_mispred", AW'(mispredict), 1);
        rst_n = 1'b0;
        #1;
        exp_br = 0;
        exp_mp = 0;
        chk("arst_update", AW'(bht_update), 0);
        chk("arst_mispred", AW'(mispredict), 0);
        chk("arst_taken", AW'(br_taken), 0);
        chk("arst_redirect", redirect_pc, 0);
        chk("arst_index", AW'(set_index), 0);
        chk_cnt("arst");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #2;
        chk("post_rst_update", AW'(bht_update), 0);
        chk_cnt("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
